// File: rtl/shr_iter.sv
// Iterative G.729 shr(var1,var2): arithmetic right shift for positive counts,
// saturating left shift for negative counts, one bit position per clock.
module shr_iter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [15:0] var1_i,
  input  logic [15:0] var2_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] result_o,
  output logic        overflow_o
);

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 5;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SHIFT_R = 2'd1;
  localparam logic [1:0] SHIFT_L = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] work_q, work_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] result_q, result_d;
  logic [DW-1:0] mag_c;

  // Magnitude of a negative count; 0x8000 stays 0x8000 and clamps to 16 below.
  assign mag_c = DW'(~var2_i + 16'd1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      work_q   <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          work_d = var1_i;
          ovf_d  = 1'b0;
          busy_d = 1'b1;
          if (!var2_i[DW-1]) begin
            cnt_d   = (var2_i > 16'd15) ? 5'd15 : var2_i[CW-1:0];
            state_d = SHIFT_R;
          end else begin
            cnt_d   = (mag_c > 16'd16) ? 5'd16 : mag_c[CW-1:0];
            state_d = SHIFT_L;
          end
        end
      end
      SHIFT_R: begin
        if (cnt_q != '0) begin
          work_d = {work_q[DW-1], work_q[DW-1:1]};
          cnt_d  = cnt_q - 5'd1;
        end else begin
          state_d  = DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = work_q;
        end
      end
      SHIFT_L: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 5'd1;
          // Sign bit is unchanged until saturation, so it still gives var1's sign.
          if (ovf_q) begin
            work_d = work_q;
          end else if (work_q[DW-1] != work_q[DW-2]) begin
            ovf_d  = 1'b1;
            work_d = work_q[DW-1] ? 16'h8000 : 16'h7FFF;
          end else begin
            work_d = {work_q[DW-2:0], 1'b0};
          end
        end else begin
          state_d  = DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = work_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign result_o   = result_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_shr_iter.sv
// Directed and random bench for shr_iter against an arithmetic model of shr().
module tb_shr_iter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] var1;
  logic [15:0] var2;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        overflow;

  int npass  = 0;
  int nfail  = 0;
  int ntotal = 0;

  shr_iter dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .var1_i     (var1),
    .var2_i     (var2),
    .busy_o     (busy),
    .done_o     (done),
    .result_o   (result),
    .overflow_o (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // shr() from its arithmetic definition: floor division or saturated multiply by 2^n.
  function automatic void model(input logic [15:0] v1, input logic [15:0] v2,
                                output logic [15:0] r, output logic o, output int n);
    int     a;
    int     s;
    longint p;
    a = int'($signed(v1));
    s = int'($signed(v2));
    o = 1'b0;
    if (s >= 0) begin
      n = (s > 15) ? 15 : s;
      r = 16'(a >>> n);
    end else begin
      n = (-s > 16) ? 16 : -s;
      p = longint'(a) * (longint'(1) << n);
      if (p > 32767) begin
        r = 16'h7FFF;
        o = 1'b1;
      end else if (p < -32768) begin
        r = 16'h8000;
        o = 1'b1;
      end else begin
        r = 16'(p);
      end
    end
  endfunction

  task automatic wait_idle();
    int c;
    c = 0;
    @(negedge clk);
    while ((busy || done) && c < 40) begin
      @(negedge clk);
      c++;
    end
    if (c >= 40) check("idle_timeout", 32'(c), 32'd0);
  endtask

  // Waits for done after the accept edge; returns cycles from accept edge.
  task automatic wait_done(input string tag, output int got);
    got = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        got = c;
        break;
      end
    end
    if (got < 0) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [15:0] v1, input logic [15:0] v2, input bit hold);
    logic [15:0] er;
    logic        eo;
    int          en;
    int          got;
    model(v1, v2, er, eo, en);
    wait_idle();
    start = 1'b1;
    var1  = v1;
    var2  = v2;
    @(posedge clk);
    #1;
    check("busy_after_accept", 32'(busy), 32'd1);
    if (!hold) begin
      start = 1'b0;
      var1  = 16'($urandom);
      var2  = 16'($urandom);
    end
    wait_done("done", got);
    check("latency", 32'(got), 32'(en + 1));
    check("result", 32'(result), 32'(er));
    check("overflow", 32'(overflow), 32'(eo));
    check("busy_at_done", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(done), 32'd0);
    if (hold) begin
      check("busy_in_idle", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      check("reaccept_after_done", 32'(busy), 32'd1);
      start = 1'b0;
      wait_done("done2", got);
      check("latency2", 32'(got), 32'(en + 1));
      check("result2", 32'(result), 32'(er));
      check("overflow2", 32'(overflow), 32'(eo));
    end
  endtask

  initial begin
    logic [15:0] rv1;
    logic [15:0] rv2;
    int          sel;
    int          got;
    rst   = 1'b1;
    start = 1'b0;
    var1  = '0;
    var2  = '0;
    #2;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op(16'h01CC, 16'h0006, 1'b0);
    check("req026_value", 32'(result), 32'h0007);
    run_op(16'hFC73, 16'h0002, 1'b0);
    check("req027_value", 32'(result), 32'hFF1C);
    run_op(16'h8000, 16'h0014, 1'b0);
    check("req027_sat_value", 32'(result), 32'hFFFF);
    run_op(16'h000F, 16'hFFF7, 1'b0);
    check("req028_value", 32'(result), 32'h1E00);
    run_op(16'h01CC, 16'hFFF9, 1'b0);
    check("req028_ovf", 32'(overflow), 32'd1);
    run_op(16'hFFFF, 16'h8000, 1'b0);
    check("req029_value", 32'(result), 32'h8000);
    run_op(16'h0000, 16'hFFF0, 1'b0);
    check("req029_zero", 32'(result), 32'h0000);
    run_op(16'h1234, 16'h0000, 1'b0);
    run_op(16'h7FFF, 16'h000F, 1'b0);
    run_op(16'h4000, 16'hFFFF, 1'b0);
    run_op(16'h0123, 16'h0005, 1'b1);

    // Reset at the midpoint of a 10-cycle shift aborts with no done pulse.
    wait_idle();
    start = 1'b1;
    var1  = 16'h01CC;
    var2  = 16'h000A;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    got = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (done) got++;
    end
    check("midrst_no_done", 32'(got), 32'd0);
    run_op(16'h01CC, 16'h0006, 1'b0);
    check("after_reset_value", 32'(result), 32'h0007);

    for (int i = 0; i < 40; i++) begin
      rv1 = 16'($urandom);
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: rv2 = 16'($urandom);
        1: rv2 = 16'($urandom_range(0, 20));
        2: rv2 = 16'(-int'($urandom_range(1, 20)));
        default: begin
          rv2 = 16'(-int'($urandom_range(1, 16)));
          rv1 = 16'($signed(16'($urandom_range(0, 255))) - 16'sd128);
        end
      endcase
      run_op(rv1, rv2, (i % 10) == 9);
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
